// File: rtl/csr_mmode_unit.sv
// csr_mmode_unit: machine-mode CSR file with trap/mret sequencing,
// interrupt arbitration and 64-bit cycle/instret counters.
module csr_mmode_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100,
  parameter bit              CNT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [4:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  input  logic            irq_take,
  input  logic [XLEN-1:0] irq_pc,
  output logic            irq_pending,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYC     = 12'hB00;
  localparam logic [11:0] A_MCYCH    = 12'hB80;
  localparam logic [11:0] A_MINS     = 12'hB02;
  localparam logic [11:0] A_MINSH    = 12'hB82;
  localparam logic [11:0] A_MVEND    = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHART    = 12'hF14;

  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam int unsigned CW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic            mst_mie;
  logic            mst_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mip_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [CW-1:0]   mcycle_q;
  logic [CW-1:0]   minstret_q;

  logic            known;
  logic [XLEN-1:0] mstatus_v;
  logic [XLEN-1:0] mip_n;
  logic [XLEN-1:0] pend;
  logic [XLEN-1:0] wval;
  logic [4:0]      irq_code;
  logic            ev_trap;
  logic            ev_irq;
  logic            ev_mret;
  logic            ev_wr;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] tgt_trap;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_mcause;

  always_comb begin
    mstatus_v = '0;
    mstatus_v[12:11] = 2'b11;
    mstatus_v[7] = mst_mpie;
    mstatus_v[3] = mst_mie;
  end

  always_comb begin
    mip_n = '0;
    mip_n[11] = irq_ext;
    mip_n[7] = irq_timer;
    mip_n[3] = irq_sw;
  end

  always_comb begin
    csr_rdata = '0;
    known = 1'b1;
    unique case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus_v;
      A_MISA:     csr_rdata = MISA_VAL;
      A_MIE:      csr_rdata = mie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      A_MIP:      csr_rdata = mip_q;
      A_MCYC:     csr_rdata = CNT_EN ? mcycle_q[XLEN-1:0] : '0;
      A_MCYCH:    csr_rdata = CNT_EN ? mcycle_q[CW-1:XLEN] : '0;
      A_MINS:     csr_rdata = CNT_EN ? minstret_q[XLEN-1:0] : '0;
      A_MINSH:    csr_rdata = CNT_EN ? minstret_q[CW-1:XLEN] : '0;
      A_MVEND, A_MARCH, A_MIMP: csr_rdata = '0;
      A_MHART:    csr_rdata = HART_ID;
      default:    known = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != 2'b00)
                     && (!known || csr_addr[11:10] == 2'b11);

  always_comb begin
    unique case (csr_op)
      OP_RS:   wval = csr_rdata | csr_wdata;
      OP_RC:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign pend = mip_q & mie_q;
  assign irq_pending = mst_mie & (|pend);

  // ext > sw > timer
  always_comb begin
    if (pend[11])     irq_code = 5'd11;
    else if (pend[3]) irq_code = 5'd3;
    else              irq_code = 5'd7;
  end

  assign ev_trap = trap_valid;
  assign ev_irq  = !trap_valid && irq_take && irq_pending;
  assign ev_mret = !trap_valid && !ev_irq && mret_valid;
  assign ev_wr   = (csr_op != 2'b00) && !csr_illegal
                 && !trap_valid && !ev_irq && !mret_valid;

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign vec_off = {{(XLEN-7){1'b0}}, irq_code, 2'b00};
  assign tgt_trap = (ev_irq && mtvec_q[1:0] == 2'b01)
                  ? tvec_base + vec_off : tvec_base;
  assign trap_epc = ev_trap ? {trap_pc[XLEN-1:2], 2'b00}
                            : {irq_pc[XLEN-1:2], 2'b00};
  assign trap_mcause = ev_trap
    ? {1'b0, {(XLEN-6){1'b0}}, trap_cause}
    : {1'b1, {(XLEN-6){1'b0}}, irq_code};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie        <= 1'b0;
      mst_mpie       <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mip_q <= mip_n;
      redirect_valid <= ev_trap | ev_irq | ev_mret;
      unique case (1'b1)
        ev_trap, ev_irq: begin
          mepc_q      <= trap_epc;
          mcause_q    <= trap_mcause;
          mtval_q     <= ev_trap ? trap_tval : '0;
          mst_mpie    <= mst_mie;
          mst_mie     <= 1'b0;
          redirect_pc <= tgt_trap;
        end
        ev_mret: begin
          mst_mie     <= mst_mpie;
          mst_mpie    <= 1'b1;
          redirect_pc <= mepc_q;
        end
        ev_wr: begin
          unique case (csr_addr)
            A_MSTATUS: begin
              mst_mie  <= wval[3];
              mst_mpie <= wval[7];
            end
            A_MIE:      mie_q      <= wval & MIE_MASK;
            A_MTVEC:    mtvec_q    <= wval;
            A_MSCRATCH: mscratch_q <= wval;
            A_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
            A_MCAUSE:   mcause_q   <= wval;
            A_MTVAL:    mtval_q    <= wval;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // A write to either half replaces it and skips that cycle's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else if (CNT_EN) begin
      if (ev_wr && csr_addr == A_MCYC)
        mcycle_q[XLEN-1:0] <= wval;
      else if (ev_wr && csr_addr == A_MCYCH)
        mcycle_q[CW-1:XLEN] <= wval;
      else
        mcycle_q <= mcycle_q + CNT_ONE;
      if (ev_wr && csr_addr == A_MINS)
        minstret_q[XLEN-1:0] <= wval;
      else if (ev_wr && csr_addr == A_MINSH)
        minstret_q[CW-1:XLEN] <= wval;
      else if (instret)
        minstret_q <= minstret_q + CNT_ONE;
    end
  end

endmodule
